// File: rtl/bridge_pkg.sv
// Shared types and defaults for the CPU-to-peripheral bridge.
package bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [31:0] MISS_DATA_DEF = 32'hbbbbbbbb;
    localparam int          TIMEOUT_DEF   = 15;

endpackage

// File: rtl/bridge_addr_decoder.sv
// Word-address window decoder; lowest matching slot wins.
module bridge_addr_decoder
    import bridge_pkg::*;
#(
    parameter int                    NUM_DEV  = 2,
    parameter logic [NUM_DEV*32-1:0] DEV_BASE = {32'h7f10, 32'h7f00},
    parameter int                    SPAN_W   = 4
) (
    input  logic [29:0]        addr,
    output logic [NUM_DEV-1:0] hit_onehot,
    output logic               any_hit
);

    logic [31:0] byte_addr;

    assign byte_addr = {addr, 2'b00};

    always_comb begin
        hit_onehot = '0;
        any_hit    = 1'b0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (!any_hit &&
                ((byte_addr >> SPAN_W) == (DEV_BASE[32*i +: 32] >> SPAN_W))) begin
                hit_onehot[i] = 1'b1;
                any_hit       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_dev_bridge.sv
// Single-outstanding CPU bridge to NUM_DEV memory-mapped devices.
module multi_dev_bridge
    import bridge_pkg::*;
#(
    parameter int                    NUM_DEV   = 2,
    parameter logic [NUM_DEV*32-1:0] DEV_BASE  = {32'h7f10, 32'h7f00},
    parameter int                    SPAN_W    = 4,
    parameter int                    TIMEOUT   = TIMEOUT_DEF,
    parameter logic [31:0]           MISS_DATA = MISS_DATA_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pr_req,
    input  logic                    pr_we,
    input  logic [29:0]             pr_addr,
    input  logic [31:0]             pr_wd,
    input  logic [3:0]              pr_be,
    output logic                    pr_ready,
    output logic                    pr_err,
    output logic [31:0]             pr_rd,
    output logic [NUM_DEV-1:0]      dev_sel,
    output logic                    dev_we,
    output logic [29:0]             dev_addr,
    output logic [31:0]             dev_wd,
    output logic [3:0]              dev_be,
    input  logic [NUM_DEV*32-1:0]   dev_rd,
    input  logic [NUM_DEV-1:0]      dev_ack,
    input  logic [NUM_DEV-1:0]      dev_irq,
    output logic [NUM_DEV-1:0]      hw_int
);

    localparam int            CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_TO = CW'(TIMEOUT);

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_DEV-1:0]   sel_q, hit_onehot;
    logic                 any_hit, we_q, ack_hit, start;
    logic [31:0]          sel_rd, rd_q;
    logic                 err_q;

    bridge_addr_decoder #(
        .NUM_DEV  (NUM_DEV),
        .DEV_BASE (DEV_BASE),
        .SPAN_W   (SPAN_W)
    ) u_dec (
        .addr       (pr_addr),
        .hit_onehot (hit_onehot),
        .any_hit    (any_hit)
    );

    assign start   = (state_q == IDLE) && pr_req;
    assign ack_hit = |(dev_ack & sel_q);

    always_comb begin
        sel_rd = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (sel_q[i]) sel_rd = sel_rd | dev_rd[32*i +: 32];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pr_req) state_d = any_hit ? ACCESS : RESP;
            end
            ACCESS: begin
                if (ack_hit || cnt_q == CNT_TO) state_d = RESP;
                if (cnt_q != CNT_TO) cnt_d = cnt_q + 1'b1;
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Response data is captured on the way into RESP and held afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q    <= '0;
            we_q     <= 1'b0;
            dev_addr <= '0;
            dev_wd   <= '0;
            dev_be   <= '0;
            rd_q     <= '0;
            err_q    <= 1'b0;
            hw_int   <= '0;
        end else begin
            hw_int <= dev_irq;
            if (start) begin
                sel_q    <= hit_onehot;
                we_q     <= pr_we;
                dev_addr <= pr_addr;
                dev_wd   <= pr_wd;
                dev_be   <= pr_be;
                if (!any_hit) begin
                    rd_q  <= MISS_DATA;
                    err_q <= 1'b1;
                end
            end
            if (state_q == ACCESS) begin
                if (ack_hit) begin
                    rd_q  <= we_q ? 32'h0 : sel_rd;
                    err_q <= 1'b0;
                end else if (cnt_q == CNT_TO) begin
                    rd_q  <= MISS_DATA;
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign dev_sel  = (state_q == ACCESS) ? sel_q : '0;
    assign dev_we   = (state_q == ACCESS) && we_q;
    assign pr_ready = (state_q == RESP);
    assign pr_rd    = rd_q;
    assign pr_err   = err_q;

endmodule

// File: tb/tb_multi_dev_bridge.sv
// Scoreboard bench for multi_dev_bridge with a simple wait-state device model.
module tb_multi_dev_bridge;

    localparam int TMO   = 15;
    localparam int NEVER = 1000;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pr_req = 1'b0;
    logic        pr_we = 1'b0;
    logic [29:0] pr_addr = '0;
    logic [31:0] pr_wd = '0;
    logic [3:0]  pr_be = '0;
    logic        pr_ready, pr_err;
    logic [31:0] pr_rd;
    logic [1:0]  dev_sel;
    logic        dev_we;
    logic [29:0] dev_addr;
    logic [31:0] dev_wd;
    logic [3:0]  dev_be;
    logic [63:0] dev_rd = {32'hcafe0001, 32'h00001234};
    logic [1:0]  dev_ack = '0;
    logic [1:0]  dev_irq = '0;
    logic [1:0]  hw_int;

    logic         reset4 = 1'b0;
    logic         pr_req4 = 1'b0;
    logic [29:0]  pr_addr4 = '0;
    logic         pr_ready4, pr_err4, dev_we4;
    logic [31:0]  pr_rd4, dev_wd4;
    logic [3:0]   dev_sel4, dev_be4, hw_int4;
    logic [29:0]  dev_addr4;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    exp_t sb[$];

    int          wait_cfg = NEVER;
    logic        ack_wrong = 1'b0;
    int          sel_cycles = 0;
    int          we_cycles = 0;
    logic [1:0]  last_sel = '0;
    logic [29:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;

    multi_dev_bridge #(
        .NUM_DEV (2),
        .TIMEOUT (TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pr_req   (pr_req),
        .pr_we    (pr_we),
        .pr_addr  (pr_addr),
        .pr_wd    (pr_wd),
        .pr_be    (pr_be),
        .pr_ready (pr_ready),
        .pr_err   (pr_err),
        .pr_rd    (pr_rd),
        .dev_sel  (dev_sel),
        .dev_we   (dev_we),
        .dev_addr (dev_addr),
        .dev_wd   (dev_wd),
        .dev_be   (dev_be),
        .dev_rd   (dev_rd),
        .dev_ack  (dev_ack),
        .dev_irq  (dev_irq),
        .hw_int   (hw_int)
    );

    // Slots 1..3 share one window so priority decides; slot 0 sits elsewhere.
    multi_dev_bridge #(
        .NUM_DEV  (4),
        .DEV_BASE ({32'h7f00, 32'h7f00, 32'h7f04, 32'h8000}),
        .TIMEOUT  (TMO)
    ) u4 (
        .clk      (clk),
        .reset    (reset4),
        .pr_req   (pr_req4),
        .pr_we    (1'b0),
        .pr_addr  (pr_addr4),
        .pr_wd    (32'h0),
        .pr_be    (4'h0),
        .pr_ready (pr_ready4),
        .pr_err   (pr_err4),
        .pr_rd    (pr_rd4),
        .dev_sel  (dev_sel4),
        .dev_we   (dev_we4),
        .dev_addr (dev_addr4),
        .dev_wd   (dev_wd4),
        .dev_be   (dev_be4),
        .dev_rd   (128'h0),
        .dev_ack  (4'h0),
        .dev_irq  (4'h0),
        .hw_int   (hw_int4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Device model: ack after wait_cfg selected cycles; optionally a stray ack
    always @(negedge clk) begin
        if (dev_sel != 2'b00) begin
            sel_cycles++;
            last_sel = dev_sel;
            if (dev_we) we_cycles++;
            if (sel_cycles - 1 == wait_cfg) begin
                dev_ack = dev_sel;
                if (dev_we) begin
                    wr_addr = dev_addr;
                    wr_data = dev_wd;
                    wr_be   = dev_be;
                end
            end else begin
                dev_ack = ack_wrong ? ~dev_sel : 2'b00;
            end
        end else begin
            dev_ack = 2'b00;
        end
    end

    // Monitor: every pr_ready pulse must match the oldest expectation
    always @(negedge clk) begin
        if (reset && pr_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_ready: got pulse at cycle %0d, required none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (pr_rd !== e.rd || pr_err !== e.err || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL %s: got rd=%h err=%b cyc=%0d, required rd=%h err=%b cyc=%0d",
                             e.nm, pr_rd, pr_err, cyc, e.rd, e.err, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic do_req(input string nm, input logic we, input logic [31:0] baddr,
                          input logic [31:0] wd, input logic [3:0] be, input int w,
                          input logic [31:0] erd, input logic eerr, input int lat);
        exp_t e;
        @(posedge clk);
        #1;
        wait_cfg   = w;
        sel_cycles = 0;
        we_cycles  = 0;
        last_sel   = '0;
        pr_req     = 1'b1;
        pr_we      = we;
        pr_addr    = baddr[31:2];
        pr_wd      = wd;
        pr_be      = be;
        e.rd  = erd;
        e.err = eerr;
        e.cyc = cyc + lat;
        e.nm  = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        pr_req = 1'b0;
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no pr_ready, required one", nm);
            sb.delete();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dev_irq = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {pr_ready, pr_err, dev_we, dev_sel, hw_int}, 32'h0);
        chk("rst_data", pr_rd | dev_wd | {2'b00, dev_addr} | {28'h0, dev_be}, 32'h0);
        dev_irq = 2'b00;
        reset   = 1'b1;
        reset4  = 1'b1;
        repeat (2) @(posedge clk);

        do_req("rd_dev0", 1'b0, 32'h7f04, 32'h0, 4'hf, 0, 32'h00001234, 1'b0, 2);
        chk("rd_dev0_sel", {30'h0, last_sel}, 32'h1);
        chk("rd_dev0_selcyc", sel_cycles, 1);

        do_req("wr_dev1", 1'b1, 32'h7f18, 32'ha5, 4'hf, 3, 32'h0, 1'b0, 5);
        chk("wr_dev1_sel", {30'h0, last_sel}, 32'h2);
        chk("wr_dev1_selcyc", sel_cycles, 4);
        chk("wr_dev1_wecyc", we_cycles, 4);
        chk("wr_dev1_addr", {2'b00, wr_addr}, 32'h1fc6);
        chk("wr_dev1_data", wr_data, 32'ha5);

        do_req("wr_be", 1'b1, 32'h7f10, 32'hdeadbeef, 4'h6, 0, 32'h0, 1'b0, 2);
        chk("wr_be_be", {28'h0, wr_be}, 32'h6);
        chk("wr_be_data", wr_data, 32'hdeadbeef);

        do_req("rd_miss", 1'b0, 32'h7f20, 32'h0, 4'hf, 0, 32'hbbbbbbbb, 1'b1, 1);
        chk("rd_miss_selcyc", sel_cycles, 0);
        do_req("wr_miss", 1'b1, 32'h0100, 32'h55, 4'hf, 0, 32'hbbbbbbbb, 1'b1, 1);
        chk("wr_miss_selcyc", sel_cycles, 0);

        do_req("timeout", 1'b0, 32'h7f00, 32'h0, 4'hf, NEVER, 32'hbbbbbbbb, 1'b1, 2 + TMO);
        chk("timeout_selcyc", sel_cycles, TMO + 1);
        do_req("ack_at_tmo", 1'b0, 32'h7f0c, 32'h0, 4'hf, TMO, 32'h00001234, 1'b0, 2 + TMO);
        do_req("ack_before_tmo", 1'b0, 32'h7f14, 32'h0, 4'hf, TMO - 1, 32'hcafe0001, 1'b0, 1 + TMO);

        ack_wrong = 1'b1;
        do_req("stray_ack", 1'b0, 32'h7f08, 32'h0, 4'hf, 3, 32'h00001234, 1'b0, 5);
        ack_wrong = 1'b0;

        // Abort an ACCESS with reset; no pulse may follow
        @(posedge clk);
        #1;
        wait_cfg = NEVER;
        pr_req   = 1'b1;
        pr_we    = 1'b1;
        pr_addr  = 30'h1fc0;
        pr_wd    = 32'h77;
        pr_be    = 4'hf;
        @(posedge clk);
        #1;
        pr_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_abort_sel", {30'h0, dev_sel}, 32'h1);
        reset = 1'b0;
        #1;
        chk("abort_outputs", {pr_ready, pr_err, dev_we, dev_sel, hw_int}, 32'h0);
        chk("abort_data", pr_rd | dev_wd | {2'b00, dev_addr} | {28'h0, dev_be}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (20) @(posedge clk);
        do_req("after_abort", 1'b0, 32'h7f1c, 32'h0, 4'hf, 1, 32'hcafe0001, 1'b0, 3);

        @(posedge clk);
        #1;
        dev_irq = 2'b10;
        @(negedge clk);
        chk("irq_latency0", {30'h0, hw_int}, 32'h0);
        @(negedge clk);
        chk("irq_latency1", {30'h0, hw_int}, 32'h2);
        #1;
        dev_irq = 2'b01;
        @(negedge clk);
        chk("irq_follow", {30'h0, hw_int}, 32'h1);

        @(posedge clk);
        #1;
        pr_req4  = 1'b1;
        pr_addr4 = 30'h1fc1;
        @(posedge clk);
        #1;
        pr_req4 = 1'b0;
        @(negedge clk);
        chk("prio_overlap", {28'h0, dev_sel4}, 32'h2);
        reset4 = 1'b0;
        @(posedge clk);
        #1;
        reset4   = 1'b1;
        pr_req4  = 1'b1;
        pr_addr4 = 30'h2002;
        @(posedge clk);
        #1;
        pr_req4 = 1'b0;
        @(negedge clk);
        chk("prio_slot0", {28'h0, dev_sel4}, 32'h1);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
